// File: rtl/jk_bank_pkg.sv
// Shared types for the JK bank arbiter: JK command encoding, arbiter FSM states
// and the index-width helper.
package jk_bank_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    CLR  = 2'b01,
    SET  = 2'b10,
    TGL  = 2'b11
  } jk_op;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    APPLY = 2'b10
  } arb_state_e;

  // Width of an index into n items, never narrower than one bit.
  function automatic int idxw(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single edge-triggered JK flip-flop with clock enable and async reset.
module jk_cell
  import jk_bank_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else if (en) begin
      case (jk_op'({j, k}))
        HOLD:    q <= q;
        CLR:     q <= 1'b0;
        SET:     q <= 1'b1;
        TGL:     q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter serialising JK commands from NREQ requesters onto a bank of
// NBITS JK cells. Define JK_BANK_ARB_ERR_EN to add the sticky err output.
module jk_bank_arbiter
  import jk_bank_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int NBITS = 6,
  localparam int IDXW  = idxw(NBITS),
  localparam int IDW   = idxw(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*IDXW-1:0] req_idx,
  input  logic [NREQ*2-1:0]    req_jk,
  output logic [NREQ-1:0]      req_ready,
  output logic [NBITS-1:0]     q,
  output logic                 gnt_valid,
  output logic [IDW-1:0]       gnt_id
`ifdef JK_BANK_ARB_ERR_EN
  ,
  output logic                 err
`endif
);

  // Handshake: a requester holds req_valid and its payload until it sees
  // req_ready high at a rising edge; the payload is captured once in IDLE and
  // later changes or a dropped valid do not affect the operation in flight.

  arb_state_e      state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  nxt_win;
  logic            any_valid;
  logic [IDXW-1:0] sel_idx;
  logic [1:0]      sel_jk;
  logic [IDXW-1:0] cap_idx;
  logic [1:0]      cap_jk;
  logic [NBITS-1:0] cell_en;
  int              cand;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    any_valid = 1'b0;
    nxt_win   = '0;
    cand      = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = (int'(ptr) + off) % NREQ;
      if (req_valid[cand]) begin
        nxt_win   = IDW'(cand);
        any_valid = 1'b1;
      end
    end
  end

  assign sel_idx = req_idx[nxt_win*IDXW +: IDXW];
  assign sel_jk  = req_jk[nxt_win*2 +: 2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      win     <= '0;
      cap_idx <= '0;
      cap_jk  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            win     <= nxt_win;
            cap_idx <= sel_idx;
            cap_jk  <= sel_jk;
            state   <= GRANT;
          end
        end
        GRANT: state <= APPLY;
        APPLY: begin
          ptr   <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // An out-of-range cap_idx matches no cell, so the bank is left untouched.
  for (genvar i = 0; i < NBITS; i++) begin : g_cell
    assign cell_en[i] = (state == GRANT) && (cap_idx == IDXW'(i));

    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .en  (cell_en[i]),
      .j   (cap_jk[1]),
      .k   (cap_jk[0]),
      .q   (q[i])
    );
  end

  assign req_ready = (state == APPLY) ? (NREQ'(1) << win) : '0;
  assign gnt_valid = (state != IDLE);
  assign gnt_id    = gnt_valid ? win : '0;

`ifdef JK_BANK_ARB_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((state == IDLE && any_valid && int'(sel_idx) >= NBITS) ||
                 (state == GRANT && !req_valid[win])) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed self-checking bench for jk_bank_arbiter (NREQ=4, NBITS=6).
module tb_jk_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [11:0] req_idx = '0;
  logic [7:0]  req_jk = '0;
  logic [3:0]  req_ready;
  logic [5:0]  q;
  logic        gnt_valid;
  logic [1:0]  gnt_id;
`ifdef JK_BANK_ARB_ERR_EN
  logic        err;
`endif

  int tests  = 0;
  int failed = 0;

  jk_bank_arbiter #(.NREQ(4), .NBITS(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_idx   (req_idx),
    .req_jk    (req_jk),
    .req_ready (req_ready),
    .q         (q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
`ifdef JK_BANK_ARB_ERR_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input int idx, input logic [1:0] jk);
    req_valid[r]       = 1'b1;
    req_idx[r*3 +: 3]  = 3'(idx);
    req_jk[r*2 +: 2]   = jk;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    check("rst_q", 32'(q), 32'h0);
    check("rst_gnt_valid", 32'(gnt_valid), 32'h0);
    rst = 1'b0;
  endtask

  // One isolated operation: capture, GRANT, APPLY with ready, back to IDLE.
  task automatic run_op(input int r, input int idx, input logic [1:0] jk, input logic [5:0] exp_q);
    set_req(r, idx, jk);
    tick();
    check("op_grant_valid", 32'(gnt_valid), 32'h1);
    check("op_grant_id", 32'(gnt_id), 32'(r));
    check("op_early_ready", 32'(req_ready), 32'h0);
    tick();
    check("op_ready", 32'(req_ready), 32'(4'(1) << r));
    check("op_q", 32'(q), 32'(exp_q));
    tick();
    check("op_ready_drop", 32'(req_ready), 32'h0);
    check("op_idle", 32'(gnt_valid), 32'h0);
    req_valid[r] = 1'b0;
  endtask

  initial begin
    logic [5:0] exp_q;
    int w;

    rst = 1'b1;
    tick();
    tick();
    check("reset_q", 32'(q), 32'h0);
    check("reset_ready", 32'(req_ready), 32'h0);
    check("reset_gnt_valid", 32'(gnt_valid), 32'h0);
    check("reset_gnt_id", 32'(gnt_id), 32'h0);
`ifdef JK_BANK_ARB_ERR_EN
    check("reset_err", 32'(err), 32'h0);
`endif
    rst = 1'b0;

    // Single SET from requester 1.
    run_op(1, 3, 2'b10, 6'b001000);

    // Two toggles from requester 0 on the same cell.
    run_op(0, 3, 2'b11, 6'b000000);
    run_op(0, 3, 2'b11, 6'b001000);

    // Out-of-range index: ready still pulses, bank unchanged.
    run_op(2, 7, 2'b10, 6'b001000);
`ifdef JK_BANK_ARB_ERR_EN
    check("err_range", 32'(err), 32'h1);
    tick();
    check("err_sticky", 32'(err), 32'h1);
`endif

    // HOLD leaves the bank alone.
    reset_pulse();
`ifdef JK_BANK_ARB_ERR_EN
    check("err_cleared", 32'(err), 32'h0);
`endif
    run_op(3, 2, 2'b10, 6'b000100);
    run_op(3, 2, 2'b00, 6'b000100);

    // All requesters valid continuously: rotation 0,1,2,3,0.
    reset_pulse();
    for (int r = 0; r < 4; r++) set_req(r, r, 2'b10);
    exp_q = '0;
    for (int n = 0; n < 5; n++) begin
      w = n % 4;
      exp_q[w] = 1'b1;
      tick();
      check("rr_grant_id", 32'(gnt_id), 32'(w));
      check("rr_early_ready", 32'(req_ready), 32'h0);
      tick();
      check("rr_ready", 32'(req_ready), 32'(4'(1) << w));
      check("rr_q", 32'(q), 32'(exp_q));
      tick();
      check("rr_ready_drop", 32'(req_ready), 32'h0);
    end
    req_valid = '0;
    check("rr_final_q", 32'(q), 32'h0f);

    // Reset during GRANT discards the operation; the held request then completes.
    reset_pulse();
    set_req(0, 5, 2'b10);
    tick();
    check("abort_in_grant", 32'(gnt_valid), 32'h1);
    rst = 1'b1;
    #1;
    check("abort_async_gnt", 32'(gnt_valid), 32'h0);
    check("abort_async_ready", 32'(req_ready), 32'h0);
    tick();
    check("abort_ready", 32'(req_ready), 32'h0);
    check("abort_q", 32'(q), 32'h0);
    rst = 1'b0;
    tick();
    check("retry_grant_id", 32'(gnt_id), 32'h0);
    check("retry_grant_valid", 32'(gnt_valid), 32'h1);
    tick();
    check("retry_ready", 32'(req_ready), 32'h1);
    check("retry_q", 32'(q), 32'h20);
    tick();
    req_valid[0] = 1'b0;

    // Valid dropped and payload changed after capture: captured op still applies.
    set_req(1, 4, 2'b10);
    tick();
    check("drop_grant_id", 32'(gnt_id), 32'h1);
    req_valid[1]    = 1'b0;
    req_idx[3 +: 3] = 3'd0;
    req_jk[2 +: 2]  = 2'b01;
    tick();
    check("drop_ready", 32'(req_ready), 32'h2);
    check("drop_q", 32'(q), 32'h30);
    tick();
    check("drop_idle", 32'(gnt_valid), 32'h0);
    check("drop_q_hold", 32'(q), 32'h30);
`ifdef JK_BANK_ARB_ERR_EN
    check("err_drop", 32'(err), 32'h1);
    reset_pulse();
    check("err_final_clear", 32'(err), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
